// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_pkg : state type, requester ids and perf constants
// Rev 1.0
// ============================================================================
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2
  } arb_state_t;

  localparam logic c_REQ_IF = 1'b0;
  localparam logic c_REQ_DM = 1'b1;

  localparam int                  c_PERF_W   = 16;
  localparam logic [c_PERF_W-1:0] c_PERF_MAX = 16'hFFFF;

  function automatic logic [c_PERF_W-1:0] perf_sat_inc(input logic [c_PERF_W-1:0] v);
    return (v == c_PERF_MAX) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_if : fetch, data and memory-side signals of the arbiter
// Rev 1.0
// ============================================================================
interface unified_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_done;
  logic [DW-1:0] if_data;
  logic          if_stall;

  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          dm_stall;

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_done, if_data, if_stall,
    output dm_done, dm_rdata, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_wr, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_done, if_data, if_stall,
    input  dm_done, dm_rdata, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/arb_lat_cnt.sv
`default_nettype none
// ============================================================================
// arb_lat_cnt : clear/load/increment access-latency counter, tc at MEM_LAT
// Rev 1.0
// ============================================================================
module arb_lat_cnt #(
  parameter int MEM_LAT = 4,
  parameter int CW      = $clog2(MEM_LAT + 1)
) (
  input  wire           clk,
  input  wire           rst,
  input  wire           i_clr,
  input  wire           i_load,
  input  wire           i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(MEM_LAT));

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter : fetch/data arbiter for one fixed-latency memory port
// Optional perf stall counters when ARB_PERF_EN is defined.  Rev 1.0
// ============================================================================
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  wire                       clk,
  input  wire                       rst,
  unified_mem_arbiter_if.slave      bus
`ifdef ARB_PERF_EN
  ,
  output logic [c_PERF_W-1:0]       perf_istall,
  output logic [c_PERF_W-1:0]       perf_dstall
`endif
);

  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_t    r_state;
  logic          r_drop;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic [CW-1:0] w_cnt;
  logic          w_tc;
  logic          w_busy, w_done, w_arb;
  logic          w_issue_d, w_issue_i, w_issue;
  logic          w_winner;
  logic          w_if_done, w_dm_done;
  logic          w_if_stall, w_dm_stall;

  assign w_busy    = (r_state != IDLE);
  assign w_done    = w_busy & w_tc;
  // Re-arbitrating in the completion cycle lets accesses issue back-to-back.
  assign w_arb     = ~w_busy | w_done;
  assign w_issue_d = w_arb & bus.dm_req;
  assign w_issue_i = w_arb & ~bus.dm_req & bus.if_req & ~bus.if_flush;
  assign w_issue   = w_issue_d | w_issue_i;
  assign w_winner  = bus.dm_req ? c_REQ_DM : c_REQ_IF;

  arb_lat_cnt #(
    .MEM_LAT (MEM_LAT),
    .CW      (CW)
  ) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_arb & ~w_issue),
    .i_load (w_issue),
    .i_inc  (w_busy & ~w_tc),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_arb) begin
        if (w_issue_d)      r_state <= ACC_D;
        else if (w_issue_i) r_state <= ACC_I;
        else                r_state <= IDLE;
      end
      if (w_issue) begin
        r_addr  <= (w_winner == c_REQ_DM) ? bus.dm_addr  : bus.if_addr;
        r_wr    <= (w_winner == c_REQ_DM) & bus.dm_wr;
        r_wdata <= (w_winner == c_REQ_DM) ? bus.dm_wdata : '0;
      end
      // Memory cannot abort, so a flushed fetch runs out with its result dropped.
      if (w_done)
        r_drop <= 1'b0;
      else if ((r_state == ACC_I) && bus.if_flush)
        r_drop <= 1'b1;
    end
  end

  assign w_if_done  = (r_state == ACC_I) & w_tc & ~r_drop & ~bus.if_flush;
  assign w_dm_done  = (r_state == ACC_D) & w_tc;
  assign w_if_stall = rst & bus.if_req & ~w_if_done;
  assign w_dm_stall = rst & bus.dm_req & ~w_dm_done;

  assign bus.if_done   = w_if_done;
  assign bus.if_data   = w_if_done ? bus.mem_rdata : '0;
  assign bus.if_stall  = w_if_stall;
  assign bus.dm_done   = w_dm_done;
  assign bus.dm_rdata  = (w_dm_done & ~r_wr) ? bus.mem_rdata : '0;
  assign bus.dm_stall  = w_dm_stall;
  assign bus.mem_en    = w_busy & (w_cnt == CW'(1));
  assign bus.mem_wr    = r_wr;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

`ifdef ARB_PERF_EN
  logic [c_PERF_W-1:0] r_perf_i;
  logic [c_PERF_W-1:0] r_perf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_i <= '0;
      r_perf_d <= '0;
    end else begin
      if (w_if_stall) r_perf_i <= perf_sat_inc(r_perf_i);
      if (w_dm_stall) r_perf_d <= perf_sat_inc(r_perf_d);
    end
  end

  assign perf_istall = r_perf_i;
  assign perf_dstall = r_perf_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// tb_unified_mem_arbiter : scoreboard bench with a fixed-latency memory model.
module tb_unified_mem_arbiter;

  localparam int MEM_LAT = 4;
  localparam int AW      = 16;
  localparam int DW      = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_PERF_EN
  logic [15:0] perf_istall;
  logic [15:0] perf_dstall;
`endif

  unified_mem_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_EN
    ,
    .perf_istall (perf_istall),
    .perf_dstall (perf_dstall)
`endif
  );

  // Memory model: read data is only meaningful in access cycle MEM_LAT.
  logic [15:0]  mem [0:511];
  logic [511:0] mem_wvld = '0;
  int           age;
  wire  [8:0]   ma = bus.mem_addr[8:0];

  function automatic logic [15:0] init_word(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h1234;
      16'h0020: return 16'h5678;
      16'h0030: return 16'h1111;
      16'h0040: return 16'h4444;
      16'h0100: return 16'h0BAD;
      16'h0002: return 16'hA0A2;
      16'h0004: return 16'hA0A4;
      default:  return a ^ 16'hC3C3;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= 0;
    end else begin
      if (bus.mem_en) age <= 2;
      else if (age != 0 && age < 64) age <= age + 1;
      if (bus.mem_en && bus.mem_wr) begin
        mem[ma]      <= bus.mem_wdata;
        mem_wvld[ma] <= 1'b1;
      end
    end
  end

  assign bus.mem_rdata = (((bus.mem_en ? 1 : age) == MEM_LAT))
                       ? (mem_wvld[ma] ? mem[ma] : init_word(bus.mem_addr))
                       : 16'hDEAD;

  typedef struct packed {
    logic        fetch;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [69:0] outs();
    return {bus.if_done, bus.if_stall, bus.if_data, bus.dm_done, bus.dm_stall,
            bus.dm_rdata, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; bus.dm_req = 1'b1;
    tick();
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_outs_1: got %h want 0", outs()); end
    tick();
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_outs_2: got %h want 0", outs()); end
    idle_inputs();
    rst = 1'b1;
    tick();
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_idle_outs: got %h want 0", outs()); end
  endtask

  task automatic test_fetch_only();
    exp_t e;
    int   stall_cnt, done_cyc, ndone;
    sb.push_back('{fetch: 1'b1, data: 16'h1234});
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    #1;
    stall_cnt = bus.if_stall ? 1 : 0;
    done_cyc = -1; ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (bus.mem_en !== (c == 1)) begin
        errors++; $display("FAIL fetch_mem_en c%0d: got %b want %b", c, bus.mem_en, (c == 1));
      end
      if (c == 1) begin
        checks++;
        if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL fetch_mem_addr: got %h want 0010", bus.mem_addr); end
      end
      if (bus.if_stall) stall_cnt++;
      if (bus.if_done) begin
        ndone++; done_cyc = c;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL fetch_sb_empty: got if_done want none"); end
        else begin
          e = sb.pop_front();
          if (!e.fetch || bus.if_data !== e.data) begin
            errors++; $display("FAIL fetch_data: got %h want %h", bus.if_data, e.data);
          end
        end
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (done_cyc != 4 || ndone != 1) begin errors++; $display("FAIL fetch_done_cycle: got c%0d n%0d want c4 n1", done_cyc, ndone); end
    checks++;
    if (stall_cnt != 4) begin errors++; $display("FAIL fetch_stall_cycles: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   dcyc, icyc;
    sb.push_back('{fetch: 1'b0, data: 16'h0000});
    sb.push_back('{fetch: 1'b1, data: 16'h5678});
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0100; bus.dm_wdata = 16'hBEEF;
    dcyc = -1; icyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {2'b11, 16'h0100, 16'hBEEF}) begin
          errors++; $display("FAIL simul_write_issue: got %b%b %h %h want 11 0100 beef",
                             bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (c == 5) begin
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr} !== {2'b10, 16'h0020}) begin
          errors++; $display("FAIL simul_fetch_issue: got %b%b %h want 10 0020", bus.mem_en, bus.mem_wr, bus.mem_addr);
        end
      end
      if (bus.dm_done) begin
        dcyc = c; checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL simul_sb_empty_dm: got dm_done want none"); end
        else begin
          e = sb.pop_front();
          if (e.fetch || bus.dm_rdata !== e.data) begin
            errors++; $display("FAIL simul_dm_data: got fetch=%b %h want fetch=%b %h", 1'b0, bus.dm_rdata, e.fetch, e.data);
          end
        end
        bus.dm_req = 1'b0; bus.dm_wr = 1'b0;
      end
      if (bus.if_done) begin
        icyc = c; checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL simul_sb_empty_if: got if_done want none"); end
        else begin
          e = sb.pop_front();
          if (!e.fetch || bus.if_data !== e.data) begin
            errors++; $display("FAIL simul_if_data: got fetch=%b %h want fetch=%b %h", 1'b1, bus.if_data, e.fetch, e.data);
          end
        end
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (dcyc != 4 || icyc != 8) begin errors++; $display("FAIL simul_done_cycles: got dm c%0d if c%0d want 4 8", dcyc, icyc); end
    checks++;
    if (!mem_wvld[256] || mem[256] !== 16'hBEEF) begin
      errors++; $display("FAIL simul_mem_write: got vld=%b %h want 1 beef", mem_wvld[256], mem[256]);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   icyc, ndone;
    bus.if_req = 1'b1; bus.if_addr = 16'h0030;
    icyc = -1; ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5) begin
        checks++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h0040}) begin
          errors++; $display("FAIL flush_reissue: got %b %h want 1 0040", bus.mem_en, bus.mem_addr);
        end
      end
      if (bus.if_done) begin
        icyc = c; ndone++; checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL flush_sb_empty: got if_done %h want none", bus.if_data); end
        else begin
          e = sb.pop_front();
          if (!e.fetch || bus.if_data !== e.data) begin
            errors++; $display("FAIL flush_data: got %h want %h", bus.if_data, e.data);
          end
        end
        bus.if_req = 1'b0;
      end
      if (c == 2) begin
        bus.if_flush = 1'b1; bus.if_addr = 16'h0040;
        sb.push_back('{fetch: 1'b1, data: 16'h4444});
      end
      if (c == 3) bus.if_flush = 1'b0;
    end
    checks++;
    if (icyc != 8 || ndone != 1) begin errors++; $display("FAIL flush_done_cycle: got c%0d n%0d want c8 n1", icyc, ndone); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   dcyc, early;
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0100;
    early = 0;
    tick(); if (bus.dm_done) early++;
    tick(); if (bus.dm_done) early++;
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL rstmid_async_outs: got %h want 0", outs()); end
    tick();
    checks++;
    if (outs() !== '0 || early != 0) begin errors++; $display("FAIL rstmid_held_outs: got %h early=%0d want 0 0", outs(), early); end
    rst = 1'b1;
    sb.push_back('{fetch: 1'b0, data: 16'hBEEF});
    dcyc = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.dm_done) begin
        dcyc = c; checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rstmid_sb_empty: got dm_done want none"); end
        else begin
          e = sb.pop_front();
          if (e.fetch || bus.dm_rdata !== e.data) begin
            errors++; $display("FAIL rstmid_data: got %h want %h", bus.dm_rdata, e.data);
          end
        end
        bus.dm_req = 1'b0;
      end
    end
    checks++;
    if (dcyc != 4) begin errors++; $display("FAIL rstmid_done_cycle: got c%0d want c4", dcyc); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   d1, d2, nd;
    logic exp_stall;
    sb.push_back('{fetch: 1'b0, data: 16'hA0A2});
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0002;
    #1;
    checks++;
    if (bus.dm_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall c0: got %b want 1", bus.dm_stall); end
    d1 = -1; d2 = -1; nd = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_stall = (c <= 8) && (c != 4) && (c != 8);
      checks++;
      if (bus.dm_stall !== exp_stall) begin
        errors++; $display("FAIL b2b_stall c%0d: got %b want %b", c, bus.dm_stall, exp_stall);
      end
      if (bus.dm_done) begin
        nd++; checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb_empty: got dm_done want none"); end
        else begin
          e = sb.pop_front();
          if (e.fetch || bus.dm_rdata !== e.data) begin
            errors++; $display("FAIL b2b_data: got %h want %h", bus.dm_rdata, e.data);
          end
        end
        if (nd == 1) begin
          d1 = c; bus.dm_addr = 16'h0004;
          sb.push_back('{fetch: 1'b0, data: 16'hA0A4});
        end else begin
          d2 = c; bus.dm_req = 1'b0;
        end
      end
    end
    checks++;
    if (nd != 2 || d1 != 4 || d2 != 8) begin errors++; $display("FAIL b2b_done_cycles: got n%0d c%0d c%0d want 2 4 8", nd, d1, d2); end
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    exp_t e;
    rst = 1'b0;
    tick();
    checks++;
    if (perf_istall !== 16'd0 || perf_dstall !== 16'd0) begin
      errors++; $display("FAIL perf_reset: got %0d %0d want 0 0", perf_istall, perf_dstall);
    end
    rst = 1'b1;
    sb.push_back('{fetch: 1'b0, data: 16'hA0A2});
    sb.push_back('{fetch: 1'b1, data: 16'h1234});
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0002;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.dm_done || bus.if_done) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL perf_sb_empty: got done want none"); end
        else begin
          e = sb.pop_front();
          if (e.fetch !== bus.if_done || (bus.if_done ? bus.if_data : bus.dm_rdata) !== e.data) begin
            errors++; $display("FAIL perf_data: got %h %h want %h", bus.if_data, bus.dm_rdata, e.data);
          end
        end
        if (bus.dm_done) bus.dm_req = 1'b0;
        if (bus.if_done) bus.if_req = 1'b0;
      end
    end
    checks++;
    if (perf_dstall !== 16'd4 || perf_istall !== 16'd8) begin
      errors++; $display("FAIL perf_counts: got d=%0d i=%0d want d=4 i=8", perf_dstall, perf_istall);
    end
    sb.push_back('{fetch: 1'b0, data: 16'hA0A2});
    bus.dm_req = 1'b1;
    force dut.r_perf_d = 16'hFFFF;
    #1;
    release dut.r_perf_d;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.dm_done) begin
        checks++;
        e = sb.pop_front();
        if (bus.dm_rdata !== e.data) begin errors++; $display("FAIL perf_sat_data: got %h want %h", bus.dm_rdata, e.data); end
        bus.dm_req = 1'b0;
      end
    end
    checks++;
    if (perf_dstall !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate: got %h want ffff", perf_dstall); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Sequences each access and returns data.
- Drives per-requester stall lines, which the pipeline uses as its fetch/memory stall controls.
- Supports a branch flush that discards an in-flight fetch result.

Parameters:
- MEM_LAT, 4: cycles from issue to read-data valid / write complete; must be ≥1.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address (PC).
- if_flush  in  1  taken branch; kill pending/in-flight fetch.
- if_done  out  1  fetch complete pulse.
- if_data  out  DW  fetched instruction; valid with if_done.
- if_stall  out  1  fetch must hold.
- dm_req  in  1  data request.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_done  out  1  data access complete pulse.
- dm_rdata  out  DW  read data; valid with dm_done.
- dm_stall  out  1  memory stage must hold.
- mem_en  out  1  memory access strobe, first access cycle only.
- mem_wr  out  1  write qualifier.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in cycle MEM_LAT of access.

Behaviour:
- FSM states: IDLE, ACC_I, ACC_D.
  - Latency counter cnt is $clog2(MEM_LAT+1) bits, zero in IDLE.
- Arbitration point: IDLE, and the completion cycle of any access, so back-to-back issue is allowed.
  - dm_req set → go to ACC_D.
  - else if_req && !if_flush → go to ACC_I.
  - else → go to IDLE.
  - Data has fixed priority over fetch (older instruction first).
- On issue edge:
  - Latch the winner's addr, wr and wdata into registers.
  - mem_addr, mem_wr and mem_wdata come from those registers for the whole access.
  - Set cnt=1.
- Access cycles 1..MEM_LAT:
  - mem_en=1 only in cycle 1.
  - cnt increments each cycle.
  - At cnt==MEM_LAT the access completes:
    - ACC_I: if_done=1, if_data=mem_rdata.
    - ACC_D: dm_done=1; dm_rdata=mem_rdata for reads, 0 for writes.
    - Then re-arbitrate.
- if_data and dm_rdata are 0 when their done is low.
- Stalls are combinational: if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done.
- Requesters must hold req, addr and wdata stable until done.
  - If req drops mid-access, the access still completes and done still pulses.
- Flush:
  - if_flush in any ACC_I cycle sets a sticky drop bit.
  - The access runs to completion, because memory cannot abort.
  - if_done is suppressed on completion; the drop bit clears on leaving ACC_I.
  - if_flush in the completion cycle also suppresses if_done.
  - if_flush never affects ACC_D.
- Reset (rst low, any cycle):
  - Immediately: state=IDLE, cnt=0, drop=0.
  - All outputs are 0, including mem_addr and mem_wdata.
  - Any in-flight access is abandoned with no done pulse.
  - First arbitration happens at the first edge after rst rises.
- MEM_LAT=1: issue and completion in the same access cycle, with mem_en and done both high.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Adds outputs perf_istall[15:0] and perf_dstall[15:0].
  - They count cycles with if_stall and dm_stall high respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package unified_mem_arbiter_pkg holds:
  - the state enum (IDLE/ACC_I/ACC_D);
  - the requester-id constants;
  - the perf counter width and saturation constant.
- One sub-module, arb_lat_cnt: a clear/load/increment counter with a terminal-count flag at MEM_LAT.

Test Plan (MEM_LAT=4; issue edge is E0, access cycles are 1..4):
- Fetch only: if_req, if_addr=0x0010, mem[0x0010]=0x1234 → mem_en in cycle 1 only; if_done with if_data=0x1234 in cycle 4; if_stall high 4 cycles.
- Simultaneous requests: if_req at 0x0020 plus dm_req write 0x0100←0xBEEF → write issued first, dm_done in cycle 4; fetch issued back-to-back, if_done in cycle 8; mem[0x0100]=0xBEEF.
- Flush: if_flush pulsed in cycle 2 of a fetch → no if_done; a following if_req at 0x0040 issues at cycle 4's edge and completes in cycle 8 with correct data.
- Reset mid-operation: rst low in cycle 2 of a data read → all outputs 0 asynchronously; no dm_done; after release, a new read of 0x0100 returns 0xBEEF 4 cycles after issue.
- Back-to-back reads at 0x0002 and 0x0004 → dm_done in cycles 4 and 8; dm_stall low only in completion cycles.
- ARB_PERF_EN: a fetch stalled behind one data access → perf_dstall=4, perf_istall=8; with the counter forced to 0xFFFF, further stall cycles keep it at 0xFFFF.
